// File: rtl/commit_trace_pkg.sv
// Shared types and defaults for the retire-trace capture block.
package commit_trace_pkg;
  localparam int XLEN_DEF   = 32;
  localparam int DEPTH_DEF  = 16;
  localparam int TS_W_DEF   = 32;
  localparam int DROP_W_DEF = 16;
  localparam int REG_W      = 5;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic                wen;
    logic [REG_W-1:0]    rd;
    logic [XLEN_DEF-1:0] wdata;
    logic [TS_W_DEF-1:0] ts;
  } trace_entry_t;

  // A retirement only carries a register write if it targets a real register.
  function automatic logic keep_wb(input logic wen, input logic [REG_W-1:0] rd);
    return wen && (rd != '0);
  endfunction
endpackage

// File: rtl/trace_fifo.sv
// Generic circular buffer: DEPTH entries of W bits, push/pop/clear, occupancy count.
module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       push_ok,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop_ok;

  assign pop_ok  = pop & (count != '0) & ~clear;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign push_ok = push & ~clear & ((count != FULL) | pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/commit_trace_buffer.sv
// Retire-trace capture: normalises writeback info, drops and counts on full.
// Define COMMIT_TRACE_TIMESTAMP_EN to stamp each entry with a free-running cycle count.
module commit_trace_buffer
  import commit_trace_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int TS_W   = TS_W_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [XLEN-1:0]            in_pc,
  input  logic                       in_wen,
  input  logic [REG_W-1:0]           in_rd,
  input  logic [XLEN-1:0]            in_wdata,
  input  logic                       freeze,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic                       out_wen,
  output logic [REG_W-1:0]           out_rd,
  output logic [XLEN-1:0]            out_wdata,
  output logic [TS_W-1:0]            out_ts,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count
);
  localparam int BODY_W = XLEN + 1 + REG_W + XLEN;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
  localparam int EW = BODY_W + TS_W;
`else
  localparam int EW = BODY_W;
`endif

  logic              keep, push_req, pop, push_ok;
  logic [BODY_W-1:0] body;
  logic [EW-1:0]     entry_in, entry_out;

  assign keep      = keep_wb(in_wen, in_rd);
  assign body      = {in_pc, keep, keep ? in_rd : '0, keep ? in_wdata : '0};
  assign push_req  = in_valid & ~freeze & ~clear;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running; freeze only gates capture, never time.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     ts_q <= '0;
    else if (clear) ts_q <= '0;
    else            ts_q <= ts_q + 1'b1;
  end

  assign entry_in = {body, ts_q};
  assign {out_pc, out_wen, out_rd, out_wdata, out_ts} = entry_out;
`else
  assign entry_in = body;
  assign {out_pc, out_wen, out_rd, out_wdata} = entry_out;
  assign out_ts   = '0;
`endif

  trace_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push_req),
    .pop     (pop),
    .clear   (clear),
    .wdata   (entry_in),
    .rdata   (entry_out),
    .push_ok (push_ok),
    .count   (count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (push_req && !push_ok) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer with a queue-based reference model.
module tb_commit_trace_buffer;
  import commit_trace_pkg::*;

  localparam int XLEN = 32, DEPTH = 16, TS_W = 32, DROP_W = 4;

  logic              clock = 1'b0, reset = 1'b0;
  logic              in_valid = 0, in_wen = 0, freeze = 0, clear = 0, out_ready = 0;
  logic [XLEN-1:0]   in_pc = '0, in_wdata = '0;
  logic [4:0]        in_rd = '0;
  logic              out_valid, out_wen, overflow;
  logic [XLEN-1:0]   out_pc, out_wdata;
  logic [4:0]        out_rd;
  logic [TS_W-1:0]   out_ts;
  logic [4:0]        count;
  logic [DROP_W-1:0] drop_count;

  int checks = 0, errors = 0;

  commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_wen(in_wen),
    .in_rd(in_rd), .in_wdata(in_wdata), .freeze(freeze), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_wen(out_wen),
    .out_rd(out_rd), .out_wdata(out_wdata), .out_ts(out_ts), .count(count),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ts_exp(input logic [31:0] t);
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    return t;
`else
    return 32'd0;
`endif
  endfunction

  // Reference model: a queue of normalised entries plus drop bookkeeping.
  trace_entry_t q[$];
  logic         m_ov;
  int           m_drop;
  logic [31:0]  m_ts;

  always @(posedge clock or negedge reset) begin
    if (!reset || clear) begin
      q.delete();
      m_ov = 0; m_drop = 0; m_ts = 0;
    end else begin
      int  pre;
      logic do_pop;
      trace_entry_t e;
      pre    = q.size();
      do_pop = (pre != 0) && out_ready;
      if (do_pop) void'(q.pop_front());
      if (in_valid && !freeze) begin
        if (pre < DEPTH || do_pop) begin
          e.pc    = in_pc;
          e.wen   = in_wen && (in_rd != 0);
          e.rd    = e.wen ? in_rd : 5'd0;
          e.wdata = e.wen ? in_wdata : 32'd0;
          e.ts    = m_ts;
          q.push_back(e);
        end else begin
          m_ov = 1;
          if (m_drop < (1 << DROP_W) - 1) m_drop++;
        end
      end
      m_ts = m_ts + 1;
    end
  end

  always @(negedge clock) begin
    if (reset === 1'b1) begin
      chk("m_count", count, q.size());
      chk("m_valid", out_valid, q.size() != 0);
      chk("m_overflow", overflow, m_ov);
      chk("m_drop", drop_count, m_drop);
      if (q.size() != 0) begin
        chk("m_pc", out_pc, q[0].pc);
        chk("m_wen", out_wen, q[0].wen);
        chk("m_rd", out_rd, q[0].rd);
        chk("m_wdata", out_wdata, q[0].wdata);
        chk("m_ts", out_ts, ts_exp(q[0].ts));
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] pc, input logic w, input logic [4:0] rd,
                      input logic [31:0] d, input logic fr, input logic cl, input logic rdy);
    in_valid = v; in_pc = pc; in_wen = w; in_rd = rd; in_wdata = d;
    freeze = fr; clear = cl; out_ready = rdy;
    @(negedge clock);
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop", drop_count, 0);
    reset = 1'b1;

    // timestamps: pushes land in cycles 5 and 9 after reset
    idle(5, 0);
    step(1, 32'h100, 1, 7, 32'h11, 0, 0, 0);
    idle(3, 0);
    step(1, 32'h104, 1, 8, 32'h22, 0, 0, 0);
    chk("ts_count", count, 2);
    chk("ts_first", out_ts, ts_exp(5));
    chk("ts_pc", out_pc, 32'h100);
    step(1, 32'h200, 1, 1, 1, 1, 0, 0);
    step(1, 32'h204, 1, 1, 1, 1, 0, 0);
    chk("freeze_count", count, 2);
    idle(1, 1);
    chk("ts_second", out_ts, ts_exp(9));
    chk("ts_pc2", out_pc, 32'h104);
    idle(1, 1);
    chk("ts_empty", out_valid, 0);

    // three entries held, then drained in order
    step(1, 32'h0, 1, 1, 32'hA, 0, 0, 0);
    step(1, 32'h4, 1, 2, 32'hB, 0, 0, 0);
    step(1, 32'h8, 1, 3, 32'hC, 0, 0, 0);
    chk("p3_count", count, 3);
    chk("p3_valid", out_valid, 1);
    chk("p3_pc", out_pc, 32'h0);
    chk("p3_wdata", out_wdata, 32'hA);
    idle(1, 1);
    chk("drain_pc1", out_pc, 32'h4);
    idle(1, 1);
    chk("drain_pc2", out_pc, 32'h8);
    chk("drain_rd2", out_rd, 3);
    idle(1, 1);
    chk("drain_empty", count, 0);

    // normalisation of x0 targets and non-writing instructions
    step(1, 32'h300, 1, 0, 32'hDEAD, 0, 0, 0);
    chk("norm_wen", out_wen, 0);
    chk("norm_rd", out_rd, 0);
    chk("norm_wdata", out_wdata, 0);
    step(1, 32'h304, 0, 5, 32'h55, 0, 0, 1);
    chk("norm2_count", count, 1);
    chk("norm2_pc", out_pc, 32'h304);
    chk("norm2_wdata", out_wdata, 0);
    idle(1, 1);

    // overflow: 20 pushes into 16 entries
    for (int i = 0; i < 20; i++) step(1, 32'h1000 + 4*i, 1, 5'(i % 31 + 1), i, 0, 0, 0);
    chk("ovf_count", count, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_count, 4);
    chk("ovf_pc", out_pc, 32'h1000);

    // full-rate push+pop on a full buffer loses nothing
    for (int i = 0; i < 10; i++) step(1, 32'h2000 + 4*i, 1, 1, i, 0, 0, 1);
    chk("thru_count", count, 16);
    chk("thru_drop", drop_count, 4);
    chk("thru_pc", out_pc, 32'h1028);

    // drop counter saturates at all-ones
    for (int i = 0; i < 12; i++) step(1, 32'h3000 + 4*i, 1, 2, i, 0, 0, 0);
    chk("sat_drop", drop_count, 15);

    // clear with count=7, overflow set, coincident push and pop ignored
    idle(9, 1);
    chk("pre_clr_count", count, 7);
    chk("pre_clr_ovf", overflow, 1);
    step(1, 32'h3F0, 1, 4, 4, 0, 1, 1);
    chk("clr_count", count, 0);
    chk("clr_valid", out_valid, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_drop", drop_count, 0);
    step(1, 32'h400, 1, 4, 32'h44, 0, 0, 0);
    chk("clr_ts", out_ts, ts_exp(0));
    idle(1, 1);

    // mixed traffic
    for (int i = 0; i < 40; i++)
      step(i % 3 != 0, 32'h5000 + 4*i, i % 2, 5'(i % 32), i * 32'h101, i % 7 == 3, 0, i % 4 < 2);

    // asynchronous reset in the middle of a drain
    for (int i = 0; i < 4; i++) step(1, 32'h6000 + 4*i, 1, 6, i, 0, 0, 0);
    idle(1, 1);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", count, 0);
    @(negedge clock);
    reset = 1'b1;
    idle(1, 1);
    chk("post_rst_valid", out_valid, 0);
    step(1, 32'h7000, 1, 9, 32'h99, 0, 0, 0);
    chk("post_rst_count", count, 1);
    chk("post_rst_pc", out_pc, 32'h7000);
    idle(2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Parametrised retire-trace capture block for the pipelined RISC-V core. It records every retired instruction reported at writeback (PC, write-enable, destination, data) into a circular buffer, with an optional cycle timestamp. A valid/ready drain port lets the testbench or a debug unit read entries without stalling the core. Entries are dropped and counted when the buffer is full.

## Interface
Parameters:
- XLEN, 32, width of PC and data fields
- DEPTH, 16, buffer entries; power of two, ≥2
- TS_W, 32, timestamp width (used only with the timestamp feature)
- DROP_W, 16, dropped-entry counter width

Ports:
- clock  in  1  single core clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  an instruction retires this cycle
- in_pc  in  XLEN  retiring PC
- in_wen  in  1  register write enable of the retiring instruction
- in_rd  in  5  destination register
- in_wdata  in  XLEN  writeback data
- freeze  in  1  suppress capture while high
- clear  in  1  synchronous flush
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head entry
- out_pc  out  XLEN  head PC
- out_wen  out  1  head write enable
- out_rd  out  5  head destination
- out_wdata  out  XLEN  head data
- out_ts  out  TS_W  head timestamp
- count  out  $clog2(DEPTH+1)  occupied entries
- overflow  out  1  sticky: at least one entry dropped
- drop_count  out  DROP_W  dropped entries, saturating

## Operation
- Push condition: in_valid & ~freeze & ~clear.
- Normalisation on capture: when in_wen=0 or in_rd=0, stored wen=0, rd=0, wdata=0.
- Push accepted if count<DEPTH, or count==DEPTH with pop in the same cycle.
- Pop condition: out_valid & out_ready.
- Rejected push: entry discarded; overflow←1; drop_count increments, saturating at all-ones.
- Simultaneous accepted push and pop: count unchanged; both pointers advance.
- Pop on empty: no effect. Pointers wrap modulo DEPTH.
- clear: pointers, count, overflow, drop_count, timestamp all return to 0; a coincident push or pop is ignored.
- out_* reflect the head entry combinationally from storage; out_* values are don't-care while out_valid=0 (bench must not check them).
- Timestamp: free-running counter, increments every cycle after reset, wraps at 2^TS_W; not halted by freeze.
- Reset (reset low, asynchronous): count=0, out_valid=0, overflow=0, drop_count=0, timestamp=0; storage contents not reset.

## Timing
- Latency: entry pushed in cycle N appears at out_valid in cycle N+1 (empty buffer).
- count, overflow, drop_count are registered; they update on the edge that ends the push/pop cycle.
- out_valid = (count != 0), derived from registered state.
- Full buffer with out_ready held high: sustained throughput of one push and one pop per cycle, no drops.
- reset asserted mid-drain: out_valid falls immediately (asynchronous), buffer reads empty after deassertion.

## Configuration
- COMMIT_TRACE_TIMESTAMP_EN defined: each entry stores the timestamp value of its push cycle; out_ts presents it.
- Not defined: no timestamp counter or storage is built; out_ts is tied to 0.

## Structure
- Package commit_trace_pkg: trace entry struct typedef (pc, wen, rd, wdata, ts), default parameter constants, register-index width constant (5).
- Sub-module trace_fifo: generic DEPTH-entry storage with read/write pointers, count, push/pop/clear; commit_trace_buffer adds normalisation, drop accounting and timestamping.

## Test plan
- Reset, push 3 entries (pc 0x0,0x4,0x8; rd 1,2,3; wdata 0xA,0xB,0xC) with out_ready=0 -> count=3, out_valid=1, head pc=0x0; then out_ready=1 drains them in order over 3 cycles.
- Push with in_wen=1, in_rd=0, in_wdata=0xDEAD -> stored wen=0, rd=0, wdata=0.
- DEPTH=16, out_ready=0, push 20 entries -> count=16, overflow=1, drop_count=4, head pc is first pushed.
- Full buffer, out_ready=1 and in_valid=1 every cycle for 10 cycles -> count stays 16, drop_count unchanged.
- With COMMIT_TRACE_TIMESTAMP_EN, push at cycles 5 and 9 after reset -> out_ts 5 then 9; freeze high blocks push while timestamp continues.
- clear asserted with count=7 and overflow=1 -> next cycle count=0, out_valid=0, overflow=0, drop_count=0.
